crypto_decrypt: RTL
===================

Name: crypto_decrypt

Overview:
- Receive-side counterpart of the datapath XOR stream encryptor.
- Sits on the 256-bit AXI-Stream path ahead of the host/DMA interface and strips the XOR keystream from arriving packets.
- Header beat 1 passes through in clear; header beat 2 is decrypted except its top 16 bits; all payload beats are fully decrypted.
- Adds per-packet key latching, a registered output stage, a bypass control and statistics counters.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master data width; only 256 supported.
- C_S_AXIS_DATA_WIDTH, 256, slave data width; must equal master.
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width.
- C_S_AXI_DATA_WIDTH, 32, register width.
- NUM_RW_REGS, 2, reg0 = key, reg1 = control.
- NUM_RO_REGS, 2, ro0 = packets decrypted, ro1 = single-beat packets.
- DEFAULT_KEY, 32'h01234567, key value used at reset.

Ports:
- axi_aclk  in  1  clock; all logic on rising edge.
- axi_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  256  input data.
- s_axis_tstrb  in  32  input byte strobes.
- s_axis_tuser  in  128  input metadata.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of packet.
- m_axis_tdata  out  256  decrypted data.
- m_axis_tstrb  out  32  strobes, passed through.
- m_axis_tuser  out  128  metadata, passed through.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  end of packet, passed through.
- rw_regs  in  64  [31:0] key; [32] enable (0 = bypass); [33] counter clear, level-sensitive.
- rw_defaults  out  64  {32'h1, DEFAULT_KEY}.
- ro_regs  out  64  [31:0] pkt_count; [63:32] short_count.

Behaviour:
- Reset values: m_axis_tvalid=0; m_axis_tdata/tstrb/tuser/tlast=0; state=HDR1; key_lat=DEFAULT_KEY; en_lat=1; both counters=0.
- Handshake:
  - accept = s_axis_tvalid & s_axis_tready.
  - s_axis_tready = ~m_axis_tvalid | m_axis_tready (combinational).
  - Output register loads on accept; m_axis_tvalid clears when m_axis_tready is high and there is no accept.
  - Data held stable while tvalid=1 and tready=0.
- Latency: exactly 1 cycle from accept to m_axis_tvalid. Full throughput of 1 beat/cycle with continuous ready.
- FSM advances only on accept:
  - HDR1: beat passed unmodified. Latch key_lat<=rw_regs[31:0] and en_lat<=rw_regs[32]. Go to HDR2, or stay in HDR1 if tlast.
  - HDR2: out[255:240]=in[255:240]; out[239:0]=in[239:0]^{key_lat[15:0],{7{key_lat}}}. Go to PAYLOAD, or HDR1 if tlast.
  - PAYLOAD: out=in^{8{key_lat}}. Stay in PAYLOAD, or go to HDR1 if tlast.
- When en_lat=0, every beat of the packet passes unmodified; the FSM still tracks beats.
- The XOR is applied to all 32 bytes regardless of tstrb. tstrb, tuser and tlast are never altered.
- Key/enable changes on rw_regs mid-packet have no effect until the next HDR1 accept.
- Counters:
  - pkt_count increments on accept of a tlast beat when en_lat=1. For a single-beat packet, use the enable value being latched in the same cycle.
  - short_count increments on accept of a tlast beat in HDR1, irrespective of enable.
  - Both counters wrap 2^32-1 → 0.
  - Clear (rw_regs[33]=1) holds both counters at 0 and beats any same-cycle increment.
- Reset mid-packet: the in-flight output beat is discarded (tvalid=0) and the FSM returns to HDR1. The next accepted beat is treated as header 1; downstream may see a truncated packet.
- Simultaneous accept and output drain: the output register is overwritten with the new beat and tvalid stays 1.

Test Plan:
- Key 0x12345678, enable=1, 3-beat packet:
  - beat0 = 256'h1 → output 256'h1.
  - beat1 = {16'hABCD, 240'h0} → {16'hABCD, 16'h5678, {7{32'h12345678}}}.
  - beat2 = {8{32'hDEADBEEF}} with tlast → {8{32'hCC99E897}}, tlast=1.
  - pkt_count=1.
- Back-to-back 2-beat packets with m_axis_tready tied to 1:
  - s_axis_tready stays 1 throughout.
  - Each output beat appears 1 cycle after its input.
  - Second packet's beat0 is unmodified.
- Backpressure: drop m_axis_tready for 5 cycles mid-payload.
  - s_axis_tready=0 after the output register fills.
  - Output data is held stable; no beats are lost or duplicated.
- Key changed to 0xFFFFFFFF during PAYLOAD of packet A:
  - A's remaining beats still use 0x12345678.
  - Packet B's HDR2/PAYLOAD beats use 0xFFFFFFFF.
- enable=0, single-beat packet, then a 3-beat packet:
  - Both packets pass unmodified.
  - short_count=1, pkt_count unchanged.
  - Then assert clear in the same cycle as a tlast accept → both counters read 0.
- Assert axi_reset for 1 cycle while in PAYLOAD with tvalid=1:
  - m_axis_tvalid=0 the next cycle.
  - Counters=0.
  - The next beat is passed unmodified as HDR1.

Source files
------------

// File: rtl/crypto_decrypt.sv
// crypto_decrypt: strips the XOR keystream from 256-bit AXI-Stream packets.
// Header beat 1 passes in clear. Header beat 2 keeps its top 16 bits and has
// the rest decrypted. Every payload beat is decrypted in full. The key and the
// enable are latched once per packet, on the header-1 accept.
module crypto_decrypt #(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
    parameter int unsigned NUM_RW_REGS          = 2,
    parameter int unsigned NUM_RO_REGS          = 2,
    parameter logic [31:0] DEFAULT_KEY          = 32'h0123_4567
) (
    input  logic                                          axi_aclk,
    input  logic                                          axi_reset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]                s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]              s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]               s_axis_tuser,
    input  logic                                          s_axis_tvalid,
    output logic                                          s_axis_tready,
    input  logic                                          s_axis_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
    output logic                                          m_axis_tlast,

    input  logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0]     rw_regs,
    output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0]     rw_defaults,
    output logic [NUM_RO_REGS*C_S_AXI_DATA_WIDTH-1:0]     ro_regs
);

    localparam int unsigned DW      = C_M_AXIS_DATA_WIDTH;
    localparam int unsigned KW      = C_S_AXI_DATA_WIDTH;
    localparam int unsigned CW      = C_S_AXI_DATA_WIDTH;
    localparam int unsigned EN_BIT  = KW;
    localparam int unsigned CLR_BIT = KW + 1;

    typedef enum logic [1:0] {
        ST_HDR1    = 2'd0,
        ST_HDR2    = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t          state;
    logic [KW-1:0]   key_lat;
    logic            en_lat;
    logic [CW-1:0]   pkt_count;
    logic [CW-1:0]   short_count;

    logic            accept_c;
    logic            last_acc_c;
    logic            pkt_en_c;
    logic [DW-1:0]   ks_c;
    logic            unused_rw;

    // Handshake: the single output register can take a beat when empty or draining
    assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
    assign accept_c      = s_axis_tvalid & s_axis_tready;
    assign last_acc_c    = accept_c & s_axis_tlast;

    // A single-beat packet is counted with the enable being latched this cycle
    assign pkt_en_c = (state == ST_HDR1) ? rw_regs[EN_BIT] : en_lat;

    assign rw_defaults = {32'h0000_0001, DEFAULT_KEY};
    assign ro_regs     = {short_count, pkt_count};

    // Control bits above the clear flag are reserved
    assign unused_rw = ^rw_regs[NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:CLR_BIT+1];

    // Keystream selected by beat position; all-zero in bypass or on header 1
    always_comb begin
        ks_c = '0;
        if (en_lat) begin
            case (state)
                ST_HDR2:    ks_c = {16'h0000, key_lat[15:0], {7{key_lat}}};
                ST_PAYLOAD: ks_c = {8{key_lat}};
                default:    ks_c = '0;
            endcase
        end
    end

    // Beat-position FSM plus the per-packet key/enable latch
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state   <= ST_HDR1;
            key_lat <= DEFAULT_KEY;
            en_lat  <= 1'b1;
        end else if (accept_c) begin
            case (state)
                ST_HDR1: begin
                    key_lat <= rw_regs[KW-1:0];
                    en_lat  <= rw_regs[EN_BIT];
                    state   <= s_axis_tlast ? ST_HDR1 : ST_HDR2;
                end
                ST_HDR2: begin
                    state <= s_axis_tlast ? ST_HDR1 : ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    state <= s_axis_tlast ? ST_HDR1 : ST_PAYLOAD;
                end
                default: begin
                    state <= ST_HDR1;
                end
            endcase
        end
    end

    // Output register: load on accept, empty once drained with nothing new
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (accept_c) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata ^ ks_c;
            m_axis_tstrb  <= s_axis_tstrb;
            m_axis_tuser  <= s_axis_tuser;
            m_axis_tlast  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Statistics: clear holds both counters at zero and beats any increment
    always_ff @(posedge axi_aclk) begin
        if (axi_reset || rw_regs[CLR_BIT]) begin
            pkt_count   <= '0;
            short_count <= '0;
        end else begin
            if (last_acc_c && pkt_en_c) begin
                pkt_count <= pkt_count + CW'(1);
            end
            if (last_acc_c && (state == ST_HDR1)) begin
                short_count <= short_count + CW'(1);
            end
        end
    end

endmodule
